// File: rtl/mem_port_mux_pkg.sv
// Shared types for the memory-port multiplexer that sits behind the round-robin arbiter.
// Holds the transaction FSM state encoding used by the top level.
package mem_port_mux_pkg;

   localparam int unsigned STATE_WIDTH = 2;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT_RD = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/mem_port_mux_flat_bus_sel.sv
// Picks one W-bit slice out of a flat NUM*W bus by index.
// An out-of-range index yields all zeros.
module mem_port_mux_flat_bus_sel #(
   parameter int unsigned NUM   = 4,
   parameter int unsigned IDX_W = 2,
   parameter int unsigned W     = 16
) (
   input  logic [NUM*W-1:0] iBus,
   input  logic [IDX_W-1:0] iIdx,
   output logic [W-1:0]     oData
);

   always_comb begin
      oData = '0;
      for (int unsigned k = 0; k < NUM; k++) begin
         if (iIdx == IDX_W'(k)) begin
            oData = iBus[k*W +: W];
         end
      end
   end

endmodule

// File: rtl/mem_port_mux.sv
// Latches the arbiter's winning client command, runs it on the shared memory port and
// returns a one-cycle ack (plus read data) to that client; one transaction in flight.
module mem_port_mux
   import mem_port_mux_pkg::*;
#(
   parameter int unsigned NUM_PORTS       = 4,
   parameter int unsigned NUM_PORTS_WIDTH = 2,
   parameter int unsigned ADDR_WIDTH      = 16,
   parameter int unsigned DATA_WIDTH      = 32
) (
   input  logic                            iClk,
   input  logic                            iReset,
   input  logic [NUM_PORTS-1:0]            iReqValid,
   input  logic [NUM_PORTS-1:0]            iReqWrite,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] iReqAddr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] iReqWData,
   output logic [NUM_PORTS-1:0]            oArbRequest,
   input  logic                            iArbActive,
   input  logic [NUM_PORTS_WIDTH-1:0]      iArbSelected,
   output logic                            oArbBusy,
   output logic [NUM_PORTS-1:0]            oAck,
   output logic [DATA_WIDTH-1:0]           oRData,
   output logic                            oMemReq,
   output logic                            oMemWrite,
   output logic [ADDR_WIDTH-1:0]           oMemAddr,
   output logic [DATA_WIDTH-1:0]           oMemWData,
   input  logic                            iMemReady,
   input  logic                            iMemRValid,
   input  logic [DATA_WIDTH-1:0]           iMemRData
);

   state_e                      r_state;
   logic [NUM_PORTS_WIDTH-1:0]  r_port;
   logic                        r_write;
   logic [ADDR_WIDTH-1:0]       r_addr;
   logic [DATA_WIDTH-1:0]       r_wdata;
   logic [DATA_WIDTH-1:0]       r_rdata;
   logic                        r_mem_req;
   logic [NUM_PORTS-1:0]        r_ack;

   logic [ADDR_WIDTH-1:0]       w_sel_addr;
   logic [DATA_WIDTH-1:0]       w_sel_wdata;
   logic                        w_sel_write;
   logic [NUM_PORTS-1:0]        w_port_onehot;

   mem_port_mux_flat_bus_sel #(
      .NUM   (NUM_PORTS),
      .IDX_W (NUM_PORTS_WIDTH),
      .W     (ADDR_WIDTH)
   ) u_addr_sel (
      .iBus  (iReqAddr),
      .iIdx  (iArbSelected),
      .oData (w_sel_addr)
   );

   mem_port_mux_flat_bus_sel #(
      .NUM   (NUM_PORTS),
      .IDX_W (NUM_PORTS_WIDTH),
      .W     (DATA_WIDTH)
   ) u_wdata_sel (
      .iBus  (iReqWData),
      .iIdx  (iArbSelected),
      .oData (w_sel_wdata)
   );

   assign w_sel_write = iReqWrite[iArbSelected];

   // An out-of-range latched port decodes to no bit, which suppresses its ack.
   always_comb begin
      w_port_onehot = '0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (r_port == NUM_PORTS_WIDTH'(k)) begin
            w_port_onehot[k] = 1'b1;
         end
      end
   end

   // Busy drops in DONE so the arbiter re-arbitrates there, with the served client masked out.
   assign oArbBusy    = ((r_state == ST_IDLE) && iArbActive) ||
                        (r_state == ST_ISSUE) || (r_state == ST_WAIT_RD);
   assign oArbRequest = iReqValid & ~((r_state == ST_DONE) ? w_port_onehot : '0);

   assign oAck      = r_ack;
   assign oRData    = r_rdata;
   assign oMemReq   = r_mem_req;
   assign oMemWrite = r_write;
   assign oMemAddr  = r_addr;
   assign oMemWData = r_wdata;

   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         r_state   <= ST_IDLE;
         r_port    <= '0;
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_mem_req <= 1'b0;
         r_ack     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (iArbActive) begin
                  r_port    <= iArbSelected;
                  r_write   <= w_sel_write;
                  r_addr    <= w_sel_addr;
                  r_wdata   <= w_sel_wdata;
                  r_rdata   <= '0;
                  r_mem_req <= 1'b1;
                  r_state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (iMemReady) begin
                  r_mem_req <= 1'b0;
                  if (r_write) begin
                     r_ack   <= w_port_onehot;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_WAIT_RD;
                  end
               end
            end
            ST_WAIT_RD: begin
               if (iMemRValid) begin
                  r_rdata <= iMemRData;
                  r_ack   <= w_port_onehot;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_ack   <= '0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ack     <= '0;
               r_mem_req <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
